// File: rtl/minc_prog_loader.sv
// Program loader for the minc instruction ROM: parses SYNC/ADDR/LEN/DATA/CSUM frames from a
// byte stream, writes DATA into program memory and holds the core in reset until a frame verifies.
`timescale 1ns/1ps
module minc_prog_loader #(
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 1024
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_nreset,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd1;
   localparam logic [2:0] ST_LEN  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

   // Running mod-256 sum; a frame is good when ADDR+LEN+DATA+CSUM folds to zero.
   function automatic logic [7:0] f_csum_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   logic [2:0]    r_state;
   logic [7:0]    r_ptr;
   logic [7:0]    r_left;
   logic [7:0]    r_sum;
   logic [CW-1:0] r_idle_cnt;
   logic          r_rx_ready;
   logic          r_mem_we;
   logic [7:0]    r_mem_addr;
   logic [7:0]    r_mem_wdata;
   logic          r_cpu_nreset;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic          w_xfer;
   logic          w_to_hit;
   logic [7:0]    w_sum_final;
   logic [2:0]    w_state_nxt;
   logic          w_ev_sync;
   logic          w_ev_data;
   logic          w_ev_good;
   logic          w_ev_bad;
   logic          w_ev_timeout;

   assign w_xfer      = rx_valid & r_rx_ready;
   assign w_to_hit    = (TIMEOUT > 0) && (r_state != ST_IDLE) && (r_idle_cnt == TO_LAST);
   assign w_sum_final = f_csum_acc(r_sum, rx_data);

   // Next-state and frame event decode; an accepted byte always wins over a same-cycle timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_ev_sync    = 1'b0;
      w_ev_data    = 1'b0;
      w_ev_good    = 1'b0;
      w_ev_bad     = 1'b0;
      w_ev_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer && (rx_data == SYNC)) begin
               w_state_nxt = ST_ADDR;
               w_ev_sync   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (w_xfer) begin
               w_state_nxt = ST_LEN;
            end else if (w_to_hit) begin
               w_state_nxt  = ST_IDLE;
               w_ev_timeout = 1'b1;
            end else begin
               w_state_nxt = ST_ADDR;
            end
         end
         ST_LEN: begin
            if (w_xfer) begin
               w_state_nxt = ST_DATA;
            end else if (w_to_hit) begin
               w_state_nxt  = ST_IDLE;
               w_ev_timeout = 1'b1;
            end else begin
               w_state_nxt = ST_LEN;
            end
         end
         ST_DATA: begin
            if (w_xfer) begin
               w_ev_data   = 1'b1;
               w_state_nxt = (r_left == 8'd1) ? ST_CSUM : ST_DATA;
            end else if (w_to_hit) begin
               w_state_nxt  = ST_IDLE;
               w_ev_timeout = 1'b1;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (w_xfer) begin
               w_state_nxt = ST_IDLE;
               if (w_sum_final == 8'h00) begin
                  w_ev_good = 1'b1;
               end else begin
                  w_ev_bad = 1'b1;
               end
            end else if (w_to_hit) begin
               w_state_nxt  = ST_IDLE;
               w_ev_timeout = 1'b1;
            end else begin
               w_state_nxt = ST_CSUM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame state, write pointer, remaining-byte count and checksum accumulator.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= ST_IDLE;
         r_ptr   <= 8'h00;
         r_left  <= 8'h00;
         r_sum   <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         if (w_ev_sync) begin
            r_sum <= 8'h00;
         end else if (w_xfer && (r_state == ST_ADDR || r_state == ST_LEN || r_state == ST_DATA)) begin
            r_sum <= f_csum_acc(r_sum, rx_data);
         end
         if (w_xfer && (r_state == ST_ADDR)) begin
            r_ptr <= rx_data;
         end else if (w_ev_data) begin
            r_ptr <= r_ptr + 8'd1;
         end
         // LEN=0 loads 0, which counts down through 8'hFF and so spans 256 data bytes.
         if (w_xfer && (r_state == ST_LEN)) begin
            r_left <= rx_data;
         end else if (w_ev_data) begin
            r_left <= r_left - 8'd1;
         end
      end
   end

   // Inter-byte idle counter, only running while a frame is open.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_idle_cnt <= {CW{1'b0}};
      end else if (w_xfer || (r_state == ST_IDLE) || w_to_hit) begin
         r_idle_cnt <= {CW{1'b0}};
      end else if (TIMEOUT > 0) begin
         r_idle_cnt <= r_idle_cnt + CW'(1'b1);
      end else begin
         r_idle_cnt <= r_idle_cnt;
      end
   end

   // Registered outputs: memory write port, core reset and status flags.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_rx_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 8'h00;
         r_mem_wdata  <= 8'h00;
         r_cpu_nreset <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_rx_ready <= 1'b1;
         r_mem_we   <= w_ev_data;
         if (w_ev_data) begin
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= rx_data;
         end
         r_busy <= (w_state_nxt != ST_IDLE);
         r_done <= w_ev_good;
         if (w_ev_sync) begin
            r_cpu_nreset <= 1'b0;
         end else if (w_ev_good) begin
            r_cpu_nreset <= 1'b1;
         end
         if (w_ev_sync || w_ev_good) begin
            r_err <= 1'b0;
         end else if (w_ev_bad || w_ev_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign rx_ready   = r_rx_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_nreset = r_cpu_nreset;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_minc_prog_loader.sv
// Directed bench for minc_prog_loader: hand-computed frames, write capture, timeout and reset abort.
`timescale 1ns/1ps
module tb_minc_prog_loader;

   logic       CLK = 1'b0;
   logic       nRESET;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_nreset;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   logic [7:0] tb_mem [256];
   int         we_cnt   = 0;
   int         done_cnt = 0;
   int         both_cnt = 0;
   int         cyc      = 0;
   int         wr_cyc [$];
   logic [7:0] wr_addr [$];

   minc_prog_loader #(.SYNC(8'hA5), .TIMEOUT(16)) dut (
      .CLK        (CLK),
      .nRESET     (nRESET),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_nreset (cpu_nreset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Capture memory writes and flag pulses mid-cycle.
   always @(negedge CLK) begin
      if (mem_we === 1'b1) begin
         tb_mem[mem_addr] = mem_wdata;
         we_cnt++;
         wr_cyc.push_back(cyc);
         wr_addr.push_back(mem_addr);
      end
      if (done === 1'b1) done_cnt++;
      if (done === 1'b1 && err === 1'b1) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic clr_log();
      we_cnt   = 0;
      done_cnt = 0;
      wr_cyc.delete();
      wr_addr.delete();
   endtask

   initial begin
      int mism;
      int snap;
      nRESET   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'hEE;

      // Reset state
      #3;
      chk("rst_outputs", {24'd0, rx_ready, mem_we, cpu_nreset, busy, done, err, 2'b00}, 32'd0);
      chk("rst_addr_data", {16'd0, mem_addr, mem_wdata}, 32'd0);
      @(negedge CLK);
      nRESET = 1'b1;
      @(posedge CLK);
      #1;
      chk("rdy_after_rst", {29'd0, rx_ready, cpu_nreset, busy}, 32'd4);

      // 1: good frame, back-to-back writes
      clr_log();
      send(8'hA5);
      chk("t1_busy_on_sync", {30'd0, busy, cpu_nreset}, 32'd2);
      send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h87);
      chk("t1_done", done, 1);
      chk("t1_status", {29'd0, cpu_nreset, busy, err}, 32'd4);
      chk("t1_we_cnt", we_cnt, 3);
      chk("t1_mem", {8'd0, tb_mem[8'h10], tb_mem[8'h11], tb_mem[8'h12]}, 32'h00112233);
      chk("t1_consec", ((wr_cyc[1] - wr_cyc[0]) == 1) && ((wr_cyc[2] - wr_cyc[1]) == 1), 1);
      @(posedge CLK);
      #1;
      chk("t1_done_1cyc", {done, done_cnt[30:0]}, 32'd1);

      // 2: bad checksum; SYNC also stops the running core
      clr_log();
      tb_mem[8'h10] = 8'h00; tb_mem[8'h11] = 8'h00; tb_mem[8'h12] = 8'h00;
      send(8'hA5);
      chk("t2_core_stopped", cpu_nreset, 0);
      send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h88);
      chk("t2_err", {29'd0, err, busy, cpu_nreset}, 32'd4);
      chk("t2_we_cnt", we_cnt, 3);
      chk("t2_mem_kept", {8'd0, tb_mem[8'h10], tb_mem[8'h11], tb_mem[8'h12]}, 32'h00112233);
      repeat (3) @(posedge CLK);
      #1;
      chk("t2_no_done", done_cnt, 0);

      // 3: address wrap FE,FF,00
      clr_log();
      send(8'hA5); send(8'hFE); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hCE);
      chk("t3_done", {29'd0, done, err, cpu_nreset}, 32'd5);
      chk("t3_addr_order", {8'd0, wr_addr[0], wr_addr[1], wr_addr[2]}, 32'h00FEFF00);
      chk("t3_mem", {8'd0, tb_mem[8'hFE], tb_mem[8'hFF], tb_mem[8'h00]}, 32'h00AABBCC);

      // 4: LEN=0 means 256 bytes
      clr_log();
      send(8'hA5); send(8'h00); send(8'h00);
      for (int i = 0; i < 256; i++) send(i[7:0]);
      send(8'h80);
      chk("t4_done", {30'd0, done, err}, 32'd2);
      chk("t4_we_cnt", we_cnt, 256);
      mism = 0;
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== i[7:0]) mism++;
      chk("t4_mem_ramp", mism, 0);

      // 5: timeout after 16 idle cycles, then stray byte, then good frame
      clr_log();
      send(8'hA5); send(8'h20); send(8'h04); send(8'h01); send(8'h02);
      repeat (15) @(posedge CLK);
      #1;
      chk("t5_pre_timeout", {30'd0, err, busy}, 32'd1);
      @(posedge CLK);
      #1;
      chk("t5_timeout", {29'd0, err, busy, cpu_nreset}, 32'd4);
      send(8'h01);
      @(posedge CLK);
      #1;
      chk("t5_stray_ignored", {busy, we_cnt[30:0]}, 32'd2);
      send(8'hA5);
      chk("t5_err_clr_on_sync", {30'd0, err, busy}, 32'd1);
      send(8'h30); send(8'h02); send(8'hA5); send(8'h5A); send(8'hCF);
      chk("t5_good_frame", {29'd0, done, err, cpu_nreset}, 32'd5);
      chk("t5_sync_as_data", {16'd0, tb_mem[8'h30], tb_mem[8'h31]}, 32'h0000A55A);

      // 6: reset mid-frame
      send(8'hA5);
      chk("t6_core_held", cpu_nreset, 0);
      clr_log();
      send(8'h50); send(8'h04); send(8'h01); send(8'h02);
      @(negedge CLK);
      #1;
      nRESET   = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h03;
      #1;
      chk("t6_rst_outputs", {24'd0, rx_ready, mem_we, cpu_nreset, busy, done, err, 2'b00}, 32'd0);
      snap = we_cnt;
      chk("t6_writes_before", snap, 2);
      repeat (3) @(posedge CLK);
      #1;
      rx_valid = 1'b0;
      chk("t6_no_write_rst", we_cnt, 2);
      @(negedge CLK);
      nRESET = 1'b1;
      @(posedge CLK);
      #1;
      send(8'h11); send(8'h22); send(8'h50);
      @(posedge CLK);
      #1;
      chk("t6_junk_ignored", {busy, mem_we, we_cnt[29:0]}, 32'd2);
      send(8'hA5);
      chk("t6_sync_after_rst", {30'd0, busy, cpu_nreset}, 32'd2);

      chk("done_err_exclusive", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
